// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register, redirect, halt on leaving text window
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter int          TEXT_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FETCH_stall,
  input  logic        FETCH_redirect,
  input  logic [31:0] FETCH_target,
  input  logic [31:0] FETCH_instruction_in,
  output logic [31:0] FETCH_PC,
  output logic [31:0] IFID_instruction,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC_plus4,
  output logic        IFID_valid,
  output logic        FETCH_halted,
  output logic [1:0]  FETCH_err,
  output logic [15:0] FETCH_count
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_END      = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;
  localparam logic [1:0] ERR_WINDOW   = 2'd3;

  // One past the last byte of the text window; 33 bits so the bound cannot wrap.
  localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + 33'(4 * TEXT_WORDS);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] ifid_instr_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic        ifid_valid_q;
  logic [1:0]  err_q;
  logic [15:0] count_q;

  logic [31:0] pc_plus4_d;
  logic        seq_legal_d;
  logic        tgt_aligned_d;
  logic        tgt_inside_d;

  // Range check only; alignment is tested separately so the error cause can be told apart.
  function automatic logic in_window(input logic [31:0] a);
    return (a >= RESET_PC) && ({1'b0, a} < WIN_END);
  endfunction

  // Candidate next addresses and their legality.
  always_comb begin
    pc_plus4_d    = pc_q + 32'd4;
    seq_legal_d   = (pc_plus4_d[1:0] == 2'b00) && in_window(pc_plus4_d);
    tgt_aligned_d = (FETCH_target[1:0] == 2'b00);
    tgt_inside_d  = in_window(FETCH_target);
  end

  // Fetch FSM: PC, IF/ID register, halt status and delivered-instruction count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_instr_q <= 32'd0;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      err_q        <= ERR_NONE;
      count_q      <= 16'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (FETCH_redirect) begin
            // Redirect wins over stall; the wrong-path word in IF/ID is always dropped.
            ifid_instr_q <= 32'd0;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            if (!tgt_aligned_d) begin
              state_q <= HALTED;
              err_q   <= ERR_MISALIGN;
            end else if (!tgt_inside_d) begin
              state_q <= HALTED;
              err_q   <= ERR_WINDOW;
            end else begin
              pc_q <= FETCH_target;
            end
          end else if (!FETCH_stall) begin
            ifid_instr_q <= FETCH_instruction_in;
            ifid_pc_q    <= pc_q;
            ifid_pc4_q   <= pc_plus4_d;
            ifid_valid_q <= 1'b1;
            count_q      <= count_q + 16'd1;
            if (seq_legal_d) begin
              pc_q <= pc_plus4_d;
            end else begin
              // PC stays on the last legal word so the memory index never leaves the array.
              state_q <= HALTED;
              err_q   <= ERR_END;
            end
          end
        end
        HALTED: begin
          ifid_instr_q <= 32'd0;
          ifid_pc_q    <= 32'd0;
          ifid_pc4_q   <= 32'd0;
          ifid_valid_q <= 1'b0;
        end
        default: begin
          state_q <= HALTED;
        end
      endcase
    end
  end

  assign FETCH_PC         = pc_q;
  assign IFID_instruction = ifid_instr_q;
  assign IFID_PC          = ifid_pc_q;
  assign IFID_PC_plus4    = ifid_pc4_q;
  assign IFID_valid       = ifid_valid_q;
  assign FETCH_halted     = (state_q == HALTED);
  assign FETCH_err        = err_q;
  assign FETCH_count      = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] B = 32'h00400000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] instr_in;
  logic [31:0] fetch_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic [1:0]  err;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(B), .TEXT_WORDS(64)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .FETCH_stall          (stall),
    .FETCH_redirect       (redirect),
    .FETCH_target         (target),
    .FETCH_instruction_in (instr_in),
    .FETCH_PC             (fetch_pc),
    .IFID_instruction     (ifid_instr),
    .IFID_PC              (ifid_pc),
    .IFID_PC_plus4        (ifid_pc4),
    .IFID_valid           (ifid_valid),
    .FETCH_halted         (halted),
    .FETCH_err            (err),
    .FETCH_count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: word i of the text window holds 0xA + i.
  logic [31:0] mem_off;
  assign mem_off  = fetch_pc - B;
  assign instr_in = 32'h0000000A + {26'd0, mem_off[7:2]};

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_ipc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_halt;
    logic [1:0]  e_err;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] t,
                              input logic [31:0] pc, input logic [31:0] ipc, input logic [31:0] inst,
                              input logic v, input logic h, input logic [1:0] e, input logic [15:0] c);
    vec_t x;
    x.rst = r; x.stall = s; x.redir = d; x.tgt = t;
    x.e_pc = pc; x.e_ipc = ipc; x.e_inst = inst; x.e_valid = v;
    x.e_halt = h; x.e_err = e; x.e_cnt = c;
    return x;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                           input logic [31:0] inst, input logic v, input logic h,
                           input logic [1:0] e, input logic [15:0] c);
    cmp({tag, ".FETCH_PC"}, fetch_pc, pc);
    cmp({tag, ".IFID_PC"}, ifid_pc, ipc);
    cmp({tag, ".IFID_PC_plus4"}, ifid_pc4, v ? ipc + 32'd4 : 32'd0);
    cmp({tag, ".IFID_instruction"}, ifid_instr, inst);
    cmp({tag, ".IFID_valid"}, {31'd0, ifid_valid}, {31'd0, v});
    cmp({tag, ".FETCH_halted"}, {31'd0, halted}, {31'd0, h});
    cmp({tag, ".FETCH_err"}, {30'd0, err}, {30'd0, e});
    cmp({tag, ".FETCH_count"}, {16'd0, count}, {16'd0, c});
  endtask

  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
    rst = r; stall = s; redirect = d; target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'd0;

    //          rst  stl  red  target      FETCH_PC    IFID_PC     instr  v  h  err  cnt
    vecs.push_back(mk(1, 0, 0, 32'd0,      B,          32'd0,      32'h0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 4,      B,          32'hA,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 8,      B + 4,      32'hB,  1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 12,     B + 8,      32'hC,  1, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 32'd0,      B,          32'd0,      32'h0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 4,      B,          32'hA,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 8,      B + 4,      32'hB,  1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 32'd0,      B + 8,      B + 4,      32'hB,  1, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 32'd0,      B + 8,      B + 4,      32'hB,  1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 12,     B + 8,      32'hC,  1, 0, 0, 3));
    vecs.push_back(mk(0, 1, 1, B + 32'h20, B + 32'h20, 32'd0,      32'h0,  0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 32'h24, B + 32'h20, 32'h12, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 1, B + 32'h22, B + 32'h24, 32'd0,      32'h0,  0, 1, 2, 4));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 32'h24, 32'd0,      32'h0,  0, 1, 2, 4));
    vecs.push_back(mk(0, 0, 1, B + 32'h20, B + 32'h24, 32'd0,      32'h0,  0, 1, 2, 4));
    vecs.push_back(mk(1, 0, 0, 32'd0,      B,          32'd0,      32'h0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, B + 32'h100, B,         32'd0,      32'h0,  0, 1, 3, 0));
    vecs.push_back(mk(1, 0, 0, 32'd0,      B,          32'd0,      32'h0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, B + 32'hFC, B + 32'hFC, 32'd0,      32'h0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 32'hFC, B + 32'hFC, 32'h49, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 32'hFC, 32'd0,      32'h0,  0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 32'd0,      B,          32'd0,      32'h0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'd0,      B + 4,      B,          32'hA,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, B - 4,      B + 4,      32'd0,      32'h0,  0, 1, 3, 1));
    vecs.push_back(mk(1, 1, 1, B + 8,      B,          32'd0,      32'h0,  0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].tgt);
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ipc, vecs[i].e_inst,
                vecs[i].e_valid, vecs[i].e_halt, vecs[i].e_err, vecs[i].e_cnt);
    end

    // Long stall straight out of reset: nothing moves.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 32'd0);
      check_all($sformatf("stall%0d", i), B, 32'd0, 32'h0, 0, 0, 0, 0);
    end

    // Last two words of the window, then the halt is sticky against further redirects.
    step(0, 0, 1, B + 32'hF8);
    check_all("tail_redir", B + 32'hF8, 32'd0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 32'd0);
    check_all("tail_w62", B + 32'hFC, B + 32'hF8, 32'h48, 1, 0, 0, 1);
    step(0, 0, 0, 32'd0);
    check_all("tail_w63", B + 32'hFC, B + 32'hFC, 32'h49, 1, 1, 1, 2);
    step(0, 1, 1, B);
    check_all("tail_ignored", B + 32'hFC, 32'd0, 32'h0, 0, 1, 1, 2);
    step(0, 0, 1, B + 32'h10);
    check_all("tail_sticky", B + 32'hFC, 32'd0, 32'h0, 0, 1, 1, 2);

    // Reset out of HALTED and run from the base again.
    step(1, 0, 0, 32'd0);
    check_all("rst_halted", B, 32'd0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 32'd0);
    check_all("restart1", B + 4, B, 32'hA, 1, 0, 0, 1);
    step(0, 0, 0, 32'd0);
    check_all("restart2", B + 8, B + 4, 32'hB, 1, 0, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the MIPS core: owns the program counter, drives the address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register for decode. It handles stall, branch/jump redirect (with IF/ID flush), and halts fetch when the PC leaves the 64-word text window starting at 0x00400000.

## Interface
- `RESET_PC`, 32'h00400000: PC value after reset; base of the text window.
- `TEXT_WORDS`, 64: number of 32-bit instruction words in the text window.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `FETCH_stall`  in  1  hazard unit requests PC and IF/ID hold.
- `FETCH_redirect`  in  1  branch taken or jump resolved this cycle.
- `FETCH_target`  in  32  redirect target byte address.
- `FETCH_instruction_in`  in  32  word returned by instruction memory for `FETCH_PC`, same cycle.
- `FETCH_PC`  out  32  current PC, to instruction memory address input.
- `IFID_instruction`  out  32  latched instruction (0 = nop when invalid).
- `IFID_PC`  out  32  address of `IFID_instruction`.
- `IFID_PC_plus4`  out  32  `IFID_PC + 4`.
- `IFID_valid`  out  1  IF/ID holds a real instruction.
- `FETCH_halted`  out  1  fetch stopped; sticky until reset.
- `FETCH_err`  out  2  halt cause: 0 none, 1 ran off end of text, 2 misaligned target, 3 target outside window.
- `FETCH_count`  out  16  number of instructions delivered to IF/ID; wraps.

## Operation
- States: RUN, HALTED. Reset → RUN. HALTED exits only on `rst`.
- Window: address A is legal iff `A[1:0]==0` and `RESET_PC <= A < RESET_PC + 4*TEXT_WORDS`. 32-bit unsigned compare; PC+4 computed modulo 2^32.
- RUN, per edge, priority `rst` > redirect > stall > sequential:
  - Redirect (regardless of stall): if target legal, PC ← target, IF/ID flushed (valid 0, instruction 0, PC fields 0). If target misaligned → HALTED, err=2; else if outside window → HALTED, err=3. PC unchanged on illegal target; IF/ID flushed either way.
  - Stall, no redirect: PC, IF/ID, count all hold.
  - Sequential: IF/ID ← {`FETCH_instruction_in`, PC, PC+4, valid 1}; count += 1. If PC+4 legal, PC ← PC+4; else PC holds, state → HALTED, err=1 (last word still delivered).
- HALTED: PC holds last legal value; IF/ID forced invalid/zero from the first halted edge; inputs ignored; count holds.
- `FETCH_PC` is always a legal address, so the memory index never leaves its array.

## Timing
- Reset values: `FETCH_PC`=`RESET_PC`, IF/ID fields 0, `IFID_valid`=0, `FETCH_halted`=0, `FETCH_err`=0, `FETCH_count`=0.
- Memory read is combinational: word for `FETCH_PC` captured at the same edge that advances the PC; fetch-to-IF/ID latency 1 cycle.
- Redirect asserted in cycle N: IF/ID invalid after edge N, target instruction in IF/ID after edge N+1 (one-bubble penalty).
- Stall is level-sensitive; any number of cycles; no output changes while held.
- `FETCH_halted`/`FETCH_err` assert on the edge that detects the condition, stay until reset.
- Reset mid-operation: all state returns to reset values at that edge, including leaving HALTED.

## Test plan
- Reset then 3 free-running cycles, memory words 0xA, 0xB, 0xC → IFID_PC 0x00400000/04/08, instructions A/B/C, valid 1, count 3, FETCH_PC 0x0040000C.
- Stall held 2 cycles at FETCH_PC 0x00400008 → FETCH_PC, IF/ID, count unchanged; release resumes with word at 0x00400008.
- Redirect + stall same cycle, target 0x00400020 → IFID_valid 0 next edge, FETCH_PC 0x00400020; following edge IFID_PC 0x00400020, valid 1.
- Redirect to 0x00400022 → halted 1, err 2, FETCH_PC unchanged, IFID_valid 0; redirect to 0x00400100 → err 3.
- Redirect to 0x004000FC, run → word 63 delivered valid, halted 1, err 1, FETCH_PC stays 0x004000FC, IFID_valid 0 afterwards.
- Assert rst while HALTED → all outputs return to reset values; fetch restarts at 0x00400000.
